// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128 encryption core, one round per clock
//
// Consumes a precomputed 1408-bit key schedule and a 128-bit block. Produces
// the ciphertext ten cycles after the input is accepted.
//
// Vectors are MSB-first in FIPS-197 byte order: byte 0 of a block is
// bits [127:120]. Round key 0 (the cipher key) is the top 128 bits of
// i_key_schedule, and round key NR is the bottom 128 bits.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_valid        input block and key schedule are valid
//   o_ready        core can accept an input this cycle
//   i_block        plaintext block
//   i_key_schedule expanded key schedule, round keys 0..NR
//   o_valid        ciphertext is valid
//   i_ready        downstream accepts the ciphertext
//   o_block        ciphertext, registered

module aes_enc_iter #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [127:0]            i_block,
  input  logic [128*(NR+1)-1:0]   i_key_schedule,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [127:0]            o_block
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   fsm;
  logic [3:0]               rnd;
  logic [127:0]             st;
  logic [0:NR][127:0]       ks_q;
  logic [0:NR][127:0]       ks_in;
  logic [127:0]             sb;
  logic [127:0]             sr;
  logic [127:0]             mc;
  logic [127:0]             round_out;
  logic                     last_round;
  logic                     accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Index 0 of the packed array lands on the top 128 bits, i.e. round key 0.
  assign ks_in = i_key_schedule;

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (st[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  // ShiftRows: byte index is 4*col + row; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // MixColumns on each 4-byte column.
  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);
    assign mc[127-32*c -: 8] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign mc[111-32*c -: 8] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign mc[103-32*c -: 8] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  end

  // The final round skips MixColumns.
  assign last_round = (rnd == 4'(NR));
  assign round_out  = (last_round ? sr : mc) ^ ks_q[rnd];

  // A finished block can be handed off and a new one accepted on the same edge.
  assign o_ready = (fsm == S_IDLE) || ((fsm == S_DONE) && i_ready);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= S_IDLE;
      rnd     <= '0;
      st      <= '0;
      ks_q    <= '0;
      o_valid <= 1'b0;
      o_block <= '0;
    end else begin
      case (fsm)
        S_RUN: begin
          st <= round_out;
          if (last_round) begin
            fsm     <= S_DONE;
            o_valid <= 1'b1;
            o_block <= round_out;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            fsm     <= S_IDLE;
          end
        end
        default: begin
        end
      endcase
      // Accept is only possible outside RUN, so it never collides with a round.
      if (accept) begin
        ks_q <= ks_in;
        st   <= i_block ^ ks_in[0];
        rnd  <= 4'd1;
        fsm  <= S_RUN;
      end
    end
  end

endmodule

// AES forward S-box as a 256-entry lookup, entry 0 in the top byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry a is 2047 - 8*a, which is {~a, 3'b111}.
  logic [10:0] idx;
  assign idx = {~a, 3'b111};
  assign y   = TABLE[idx -: 8];

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - directed self-checking bench for aes_enc_iter

module tb_aes_enc_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [127:0]   i_block = '0;
  logic [1407:0]  i_key_schedule = '0;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [127:0]   o_block;

  logic [1407:0]  ks_c1, ks_b, ks_z;
  int             n_checks = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  aes_enc_iter #(.NR(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_block        (i_block),
    .i_key_schedule (i_key_schedule),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_block        (o_block)
  );

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] idx;
    idx = {~a, 3'b111};
    return SBOX[idx -: 8];
  endfunction

  // FIPS-197 key expansion; words w0..w43 packed MSB-first.
  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [127:0]  k;
    logic [1407:0] ks;
    rcon = 8'h01;
    k    = key;
    for (int i = 0; i < 4; i++) begin
      w[i] = k[127:96];
      k    = k << 32;
    end
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    ks = '0;
    for (int i = 0; i < 44; i++) ks = {ks[1375:0], w[i]};
    return ks;
  endfunction

  // Presents a block and returns #1 after the edge that accepted it.
  task automatic send(input logic [127:0] blk, input logic [1407:0] ks);
    int waited;
    i_block        = blk;
    i_key_schedule = ks;
    i_valid        = 1'b1;
    waited         = 0;
    while (!o_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (waited >= 50) begin n_fail++; $display("FAIL send_timeout: o_ready stayed %0b for %0d cycles", o_ready, waited); end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!o_valid && cycles < 40);
  endtask

  task automatic release_output();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_block !== 128'h0) begin n_fail++; $display("FAIL reset_o_block: got %h want 0", o_block); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %0b want 1", o_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_c1();
    int cyc;
    i_ready = 1'b0;
    send(C1_PT, ks_c1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL c1_latency: got %0d cycles want 10", cyc); end
    n_checks++; if (o_block !== C1_CT) begin n_fail++; $display("FAIL c1_block: got %h want %h", o_block, C1_CT); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL c1_done_not_ready: got %0b want 0", o_ready); end
    i_ready = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL c1_done_ready: got %0b want 1", o_ready); end
    @(posedge clk); #1;
    i_ready = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL c1_handoff_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL c1_idle_ready: got %0b want 1", o_ready); end
    n_checks++; if (o_block !== C1_CT) begin n_fail++; $display("FAIL c1_block_hold: got %h want %h", o_block, C1_CT); end
  endtask

  task automatic test_key_corrupt();
    int cyc;
    i_ready = 1'b0;
    send(B_PT, ks_b);
    i_key_schedule = ~ks_b;
    i_block        = ~B_PT;
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL b_run_ready: got %0b want 0", o_ready); end
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL b_latency: got %0d cycles want 10", cyc); end
    n_checks++; if (o_block !== B_CT) begin n_fail++; $display("FAIL b_block: got %h want %h", o_block, B_CT); end
    release_output();
  endtask

  task automatic test_gcm_subkey();
    int cyc;
    i_ready = 1'b0;
    send(128'h0, ks_z);
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL gcm_latency: got %0d cycles want 10", cyc); end
    n_checks++; if (o_block !== Z_CT) begin n_fail++; $display("FAIL gcm_h: got %h want %h", o_block, Z_CT); end
    release_output();
  endtask

  task automatic test_backpressure();
    int cyc;
    i_ready = 1'b0;
    send(C1_PT, ks_c1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL bp_latency: got %0d cycles want 10", cyc); end
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %0b want 1", k, o_valid); end
      n_checks++; if (o_block !== C1_CT) begin n_fail++; $display("FAIL bp_block_hold[%0d]: got %h want %h", k, o_block, C1_CT); end
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low[%0d]: got %0b want 0", k, o_ready); end
    end
    i_ready        = 1'b1;
    i_valid        = 1'b1;
    i_block        = B_PT;
    i_key_schedule = ks_b;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_handoff: got %0b want 1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_new_run_ready: got %0b want 0", o_ready); end
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL bp_second_latency: got %0d cycles want 10", cyc); end
    n_checks++; if (o_block !== B_CT) begin n_fail++; $display("FAIL bp_second_block: got %h want %h", o_block, B_CT); end
    release_output();
  endtask

  task automatic test_reset_mid();
    int cyc;
    i_ready = 1'b0;
    send(C1_PT, ks_c1);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_o_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_block !== 128'h0) begin n_fail++; $display("FAIL rm_o_block: got %h want 0", o_block); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rm_o_ready: got %0b want 1", o_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_held_valid: got %0b want 0", o_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(C1_PT, ks_c1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL rm_latency: got %0d cycles want 10", cyc); end
    n_checks++; if (o_block !== C1_CT) begin n_fail++; $display("FAIL rm_block: got %h want %h", o_block, C1_CT); end
    release_output();
  endtask

  task automatic test_back_to_back();
    logic [127:0]  blks [4];
    logic [1407:0] kss  [4];
    logic [127:0]  exps [4];
    logic [127:0]  outs [4];
    int            acc_cyc [4];
    int            idx, nout, cyc;
    logic          acc;
    blks[0] = C1_PT;  kss[0] = ks_c1; exps[0] = C1_CT;
    blks[1] = B_PT;   kss[1] = ks_b;  exps[1] = B_CT;
    blks[2] = 128'h0; kss[2] = ks_z;  exps[2] = Z_CT;
    blks[3] = C1_PT;  kss[3] = ks_c1; exps[3] = C1_CT;
    for (int k = 0; k < 4; k++) begin acc_cyc[k] = 0; outs[k] = '0; end
    idx = 0; nout = 0; cyc = 0;
    i_ready        = 1'b1;
    i_block        = blks[0];
    i_key_schedule = kss[0];
    i_valid        = 1'b1;
    while (nout < 4 && cyc < 100) begin
      acc = i_valid && o_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          i_block        = blks[idx];
          i_key_schedule = kss[idx];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (o_valid) begin
        outs[nout] = o_block;
        nout++;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    n_checks++; if (nout !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d blocks want 4", nout); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (acc_cyc[k+1] - acc_cyc[k] !== 11) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 11", k, acc_cyc[k+1] - acc_cyc[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (outs[k] !== exps[k]) begin n_fail++; $display("FAIL b2b_block[%0d]: got %h want %h", k, outs[k], exps[k]); end
    end
  endtask

  initial begin
    ks_c1 = expand_key(C1_KEY);
    ks_b  = expand_key(B_KEY);
    ks_z  = expand_key(128'h0);
    test_reset();
    test_fips_c1();
    test_key_corrupt();
    test_gcm_subkey();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
